// File: rtl/mips_enc_if.sv
// Command/output bus of the MIPS instruction encoder.
// Commands flow into the encoder; encoded words flow out. Both use valid/ready.
interface mips_enc_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [4:0]            cmd_mnem;
  logic [4:0]            cmd_rs;
  logic [4:0]            cmd_rt;
  logic [4:0]            cmd_rd;
  logic [4:0]            cmd_shamt;
  logic [25:0]           cmd_imm;
  logic                  cmd_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_word;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output cmd_valid, cmd_mnem, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm, cmd_last,
    output out_ready,
    input  cmd_ready, out_valid, out_word, out_addr
  );

  modport slave (
    input  cmd_valid, cmd_mnem, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm, cmd_last,
    input  out_ready,
    output cmd_ready, out_valid, out_word, out_addr
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS commands into 32-bit words at sequential byte addresses.
// Optional macro ENC_CHECKSUM_EN adds a running XOR checksum of output words.
module mips_instr_encoder #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MAX_WORDS  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  mips_enc_if.slave  bus,
  output logic       busy,
  output logic       done,
  output logic       err_illegal,
  output logic       err_overflow
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  cmd_ready;
  logic                  accept;
  logic                  start_session;
  logic                  set_overflow;
  logic                  at_limit;
  logic                  out_hs;
  logic [31:0]           enc_word;
  logic                  enc_illegal;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] func);
    return {6'd0, rs, rt, rd, sh, func};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Mnemonic to instruction word, with the field forcing each format requires
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (bus.cmd_mnem)
      5'd0:  enc_word = r_word(5'd0, bus.cmd_rt, bus.cmd_rd, bus.cmd_shamt, 6'd0);
      5'd1:  enc_word = r_word(5'd0, bus.cmd_rt, bus.cmd_rd, bus.cmd_shamt, 6'd3);
      5'd2:  enc_word = r_word(5'd0, bus.cmd_rt, bus.cmd_rd, bus.cmd_shamt, 6'd2);
      5'd3:  enc_word = r_word(bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'd0, 6'd32);
      5'd4:  enc_word = r_word(bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'd0, 6'd33);
      5'd5:  enc_word = r_word(bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'd0, 6'd34);
      5'd6:  enc_word = r_word(bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'd0, 6'd36);
      5'd7:  enc_word = r_word(bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'd0, 6'd37);
      5'd8:  enc_word = r_word(bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'd0, 6'd39);
      5'd9:  enc_word = r_word(bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'd0, 6'd42);
      5'd10: enc_word = r_word(bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'd0, 6'd43);
      5'd11: enc_word = r_word(bus.cmd_rs, 5'd0, 5'd0, 5'd0, 6'd8);
      5'd12: enc_word = 32'h0000_000C;
      5'd13: enc_word = {6'd2, bus.cmd_imm};
      5'd14: enc_word = {6'd3, bus.cmd_imm};
      5'd15: enc_word = i_word(6'd4,  bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
      5'd16: enc_word = i_word(6'd5,  bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
      5'd17: enc_word = i_word(6'd8,  bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
      5'd18: enc_word = i_word(6'd12, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
      5'd19: enc_word = i_word(6'd9,  bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
      5'd20: enc_word = i_word(6'd10, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
      5'd21: enc_word = i_word(6'd13, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
      5'd22: enc_word = i_word(6'd35, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
      5'd23: enc_word = i_word(6'd43, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
      default: enc_illegal = 1'b1;
    endcase
  end

  assign out_hs        = bus.out_valid & bus.out_ready;
  assign at_limit      = (count_q == CNT_W'(MAX_WORDS - 1));
  assign bus.cmd_ready = cmd_ready;

  // Session control; the last command wins over the capacity limit
  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    accept        = 1'b0;
    start_session = 1'b0;
    set_overflow  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = LOAD;
          start_session = 1'b1;
        end
      end
      LOAD: begin
        cmd_ready = ~bus.out_valid | bus.out_ready;
        accept    = bus.cmd_valid & cmd_ready;
        if (accept && bus.cmd_last) begin
          state_d = DRAIN;
        end else if (accept && at_limit) begin
          state_d      = DRAIN;
          set_overflow = 1'b1;
        end
      end
      DRAIN: begin
        if (!bus.out_valid || bus.out_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, single-entry output register, address/count and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_illegal   <= 1'b0;
      err_overflow  <= 1'b0;
      addr_q        <= BASE_ADDR;
      count_q       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_word  <= '0;
      bus.out_addr  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      if (start_session) begin
        addr_q       <= BASE_ADDR;
        count_q      <= '0;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_word  <= enc_word;
        bus.out_addr  <= addr_q;
        addr_q        <= addr_q + ADDR_WIDTH'(4);
        count_q       <= count_q + CNT_W'(1);
        if (enc_illegal)  err_illegal  <= 1'b1;
        if (set_overflow) err_overflow <= 1'b1;
      end else if (out_hs) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  // Running XOR of every word taken by the downstream write port
  always_ff @(posedge clk) begin
    if (!rst_n)             checksum <= '0;
    else if (start_session) checksum <= '0;
    else if (out_hs)        checksum <= checksum ^ bus.out_word;
  end
`endif

endmodule
